// File: rtl/if_id_hazard_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC, IF/ID register, load-use hazard detect and branch redirect.
// Define PERF_COUNTERS_EN to add the saturating Stall_count / Squash_count outputs.
module if_id_hazard_stage #(
  parameter int unsigned     word     = 32,
  parameter int unsigned     rwidth   = 5,
  parameter logic [word-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [word-1:0]   IM_Read_data,
  input  logic              ID_Branch_taken,
  input  logic [word-1:0]   ID_Branch_target,
  input  logic              ID_EX_MemRead,
  input  logic [rwidth-1:0] ID_EX_RegisterRt,
  output logic [word-1:0]   IF_PC,
  output logic [word-1:0]   IF_ID_Instruction,
  output logic [word-1:0]   IF_ID_PC_plus4,
  output logic [rwidth-1:0] IF_ID_RegisterRs,
  output logic [rwidth-1:0] IF_ID_RegisterRt,
  output logic [rwidth-1:0] IF_ID_RegisterRd,
  output logic              Stall,
  output logic              ID_EX_Flush
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0]       Stall_count,
  output logic [31:0]       Squash_count
`endif
);

  logic [word-1:0] pc_plus4;

  assign pc_plus4 = IF_PC + word'(4);

  assign IF_ID_RegisterRs = IF_ID_Instruction[25:21];
  assign IF_ID_RegisterRt = IF_ID_Instruction[20:16];
  assign IF_ID_RegisterRd = IF_ID_Instruction[15:11];

  // Load in EX whose destination is a source of the instruction in ID; $zero never hazards.
  always_comb begin
    Stall = 1'b0;
    if (ID_EX_MemRead && (ID_EX_RegisterRt != '0) &&
        ((ID_EX_RegisterRt == IF_ID_RegisterRs) || (ID_EX_RegisterRt == IF_ID_RegisterRt)))
      Stall = 1'b1;
    ID_EX_Flush = Stall;
  end

  // A stall freezes everything, which also drops a concurrent branch until ID re-resolves it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      IF_PC             <= RESET_PC;
      IF_ID_Instruction <= '0;
      IF_ID_PC_plus4    <= '0;
    end else if (Stall) begin
      IF_PC             <= IF_PC;
      IF_ID_Instruction <= IF_ID_Instruction;
      IF_ID_PC_plus4    <= IF_ID_PC_plus4;
    end else if (ID_Branch_taken) begin
      IF_PC             <= ID_Branch_target;
      IF_ID_Instruction <= '0;
      IF_ID_PC_plus4    <= '0;
    end else begin
      IF_PC             <= pc_plus4;
      IF_ID_Instruction <= IM_Read_data;
      IF_ID_PC_plus4    <= pc_plus4;
    end
  end

`ifdef PERF_COUNTERS_EN
  localparam logic [31:0] CNT_MAX = '1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Stall_count  <= '0;
      Squash_count <= '0;
    end else begin
      if (Stall && (Stall_count != CNT_MAX))
        Stall_count <= Stall_count + 32'(1);
      if (ID_Branch_taken && !Stall && (Squash_count != CNT_MAX))
        Squash_count <= Squash_count + 32'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Directed plus randomized bench for if_id_hazard_stage against a cycle-level reference model.
module tb_if_id_hazard_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clock;
  logic        Reset;
  logic [31:0] IM_Read_data;
  logic        ID_Branch_taken;
  logic [31:0] ID_Branch_target;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_RegisterRt;
  logic [31:0] IF_PC;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PC_plus4;
  logic [4:0]  IF_ID_RegisterRs;
  logic [4:0]  IF_ID_RegisterRt;
  logic [4:0]  IF_ID_RegisterRd;
  logic        Stall;
  logic        ID_EX_Flush;
`ifdef PERF_COUNTERS_EN
  logic [31:0] Stall_count;
  logic [31:0] Squash_count;
`endif

  if_id_hazard_stage #(.word(32), .rwidth(5), .RESET_PC(RESET_PC)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .IM_Read_data(IM_Read_data),
    .ID_Branch_taken(ID_Branch_taken),
    .ID_Branch_target(ID_Branch_target),
    .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .IF_PC(IF_PC),
    .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PC_plus4(IF_ID_PC_plus4),
    .IF_ID_RegisterRs(IF_ID_RegisterRs),
    .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .IF_ID_RegisterRd(IF_ID_RegisterRd),
    .Stall(Stall),
    .ID_EX_Flush(ID_EX_Flush)
`ifdef PERF_COUNTERS_EN
    ,
    .Stall_count(Stall_count),
    .Squash_count(Squash_count)
`endif
  );

  // Instruction memory: 256 words, aliased on address bits [9:2].
  logic [31:0] mem [0:255];
  assign IM_Read_data = mem[IF_PC[9:2]];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic [31:0] m_stall_cnt, m_squash_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = 32'h0; m_pc4 = 32'h0;
    m_stall_cnt = 32'h0; m_squash_cnt = 32'h0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".pc"},    IF_PC,             m_pc);
    check({tag, ".instr"}, IF_ID_Instruction, m_instr);
    check({tag, ".pc4"},   IF_ID_PC_plus4,    m_pc4);
    check({tag, ".rs"},    32'(IF_ID_RegisterRs), 32'(m_instr[25:21]));
    check({tag, ".rt"},    32'(IF_ID_RegisterRt), 32'(m_instr[20:16]));
    check({tag, ".rd"},    32'(IF_ID_RegisterRd), 32'(m_instr[15:11]));
`ifdef PERF_COUNTERS_EN
    check({tag, ".stall_cnt"},  Stall_count,  m_stall_cnt);
    check({tag, ".squash_cnt"}, Squash_count, m_squash_cnt);
`endif
  endtask

  // One pipeline cycle: drive at negedge, check the combinational hazard, then the registered result.
  task automatic step(input string tag, input logic br, input logic [31:0] tgt,
                      input logic mr, input logic [4:0] rt);
    logic exp_stall;
    @(negedge Clock);
    ID_Branch_taken  = br;
    ID_Branch_target = tgt;
    ID_EX_MemRead    = mr;
    ID_EX_RegisterRt = rt;
    #1;
    exp_stall = mr && (rt != 5'd0) && (rt == m_instr[25:21] || rt == m_instr[20:16]);
    check({tag, ".stall"}, 32'(Stall),       32'(exp_stall));
    check({tag, ".flush"}, 32'(ID_EX_Flush), 32'(exp_stall));
    @(posedge Clock);
    #1;
    if (exp_stall) begin
      if (m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
    end else if (br) begin
      if (m_squash_cnt != 32'hFFFF_FFFF) m_squash_cnt = m_squash_cnt + 1;
      m_pc = tgt; m_instr = 32'h0; m_pc4 = 32'h0;
    end else begin
      m_instr = mem[m_pc[9:2]];
      m_pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
    end
    check_regs(tag);
  endtask

  initial begin
    logic [4:0]  r_rt;
    logic [31:0] r_tgt;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0]  = 32'h2008_0005;        // addi $8,$0,5
    mem[1]  = 32'h0109_4820;        // add  $9,$8,$9
    mem[15] = 32'h0109_4820;        // at 0x3C
    Reset = 1'b1;
    ID_Branch_taken = 1'b0; ID_Branch_target = 32'h0;
    ID_EX_MemRead = 1'b0; ID_EX_RegisterRt = 5'd0;
    model_reset();

    // Reset held across an edge
    @(posedge Clock);
    #2;
    check_regs("reset");
    Reset = 1'b0;

    // First fetch, then load-use stall on Rs=8, then release
    step("fetch0", 1'b0, 32'h0, 1'b0, 5'd0);
    check("fetch0.pc_abs", IF_PC, 32'h4);
    check("fetch0.instr_abs", IF_ID_Instruction, 32'h2008_0005);
    step("fetch1", 1'b0, 32'h0, 1'b0, 5'd0);
    step("loaduse", 1'b0, 32'h0, 1'b1, 5'd8);
    check("loaduse.pc_abs", IF_PC, 32'h8);
    step("loaduse_rel", 1'b0, 32'h0, 1'b0, 5'd8);
    check("loaduse_rel.pc_abs", IF_PC, 32'hC);

    // Branch to 0x40, then 0x100, then $zero load with Rs=0
    step("br40", 1'b1, 32'h40, 1'b0, 5'd0);
    step("br100", 1'b1, 32'h100, 1'b0, 5'd0);
    check("br100.pc_abs", IF_PC, 32'h100);
    check("br100.instr_abs", IF_ID_Instruction, 32'h0);
    step("zero_rt", 1'b0, 32'h0, 1'b1, 5'd0);
    check("zero_rt.pc_abs", IF_PC, 32'h104);

    // Stall coinciding with a taken branch at PC 0x40
    step("br3c", 1'b1, 32'h3C, 1'b0, 5'd0);
    step("to40", 1'b0, 32'h0, 1'b0, 5'd0);
    step("stall_br", 1'b1, 32'h100, 1'b1, 5'd9);
    check("stall_br.pc_abs", IF_PC, 32'h40);
    step("br_after", 1'b1, 32'h100, 1'b0, 5'd9);
    check("br_after.pc_abs", IF_PC, 32'h100);

    // PC wrap and unaligned target
    step("brtop", 1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0);
    step("wrap", 1'b0, 32'h0, 1'b0, 5'd0);
    check("wrap.pc_abs", IF_PC, 32'h0);
    step("unaligned", 1'b1, 32'h0000_0123, 1'b0, 5'd0);
    step("after_unal", 1'b0, 32'h0, 1'b0, 5'd0);

    // Asynchronous reset between edges
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check_regs("async_rst");
    Reset = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       r_rt = m_instr[25:21];
        1:       r_rt = m_instr[20:16];
        default: r_rt = 5'($urandom);
      endcase
      r_tgt = $urandom;
      if ($urandom_range(0, 3) != 0) r_tgt[1:0] = 2'b00;
      step("rand", ($urandom_range(0, 3) == 0), r_tgt, 1'($urandom_range(0, 1)), r_rt);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
